// File: rtl/aes_key_schedule_multi_if.sv
// Key-schedule bus: cipher key, mode and start request in; round key, ready and error out.
// AES_KEY_INV_SEL_EN adds key_dir for reverse round-key indexing.
interface aes_key_schedule_multi_if #(
  parameter int MAX_KEY_WIDTH = 256
);
  logic [MAX_KEY_WIDTH-1:0] cipher_key;
  logic [1:0]               key_mode;
  logic                     encrypt_en;
  logic [3:0]               key_sel;
`ifdef AES_KEY_INV_SEL_EN
  logic                     key_dir;
`endif
  logic                     key_rdy;
  logic                     key_err;
  logic [127:0]             round_key;

  // encrypt_en is a level request, accepted only in IDLE/DONE on a clk edge; there is
  // no back-pressure. key_rdy is a status level meaning round_key lookups are valid.
  modport master (
    output cipher_key, key_mode, encrypt_en, key_sel,
`ifdef AES_KEY_INV_SEL_EN
    output key_dir,
`endif
    input  key_rdy, key_err, round_key
  );

  modport slave (
    input  cipher_key, key_mode, encrypt_en, key_sel,
`ifdef AES_KEY_INV_SEL_EN
    input  key_dir,
`endif
    output key_rdy, key_err, round_key
  );
endinterface

// File: rtl/aes_key_schedule_multi.sv
// Iterative AES-128/192/256 key expander: one schedule word per clock into a word store,
// then registered round-key lookup by index. Optional macro AES_KEY_INV_SEL_EN: reverse indexing.
module aes_key_schedule_multi #(
  parameter int MAX_KEY_WIDTH = 256,
  parameter int WORD_DEPTH    = 60
) (
  input  logic                          clk,
  input  logic                          resetn,
  aes_key_schedule_multi_if.slave       bus,
  output logic [1:0]                    dbg_state_o
);
  localparam int IW = $clog2(WORD_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_EXPAND = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    sbox = SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [3:0] mode_nk(input logic [1:0] m);
    case (m)
      2'd0:    mode_nk = 4'd4;
      2'd1:    mode_nk = 4'd6;
      default: mode_nk = 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] mode_nr(input logic [1:0] m);
    case (m)
      2'd0:    mode_nr = 4'd10;
      2'd1:    mode_nr = 4'd12;
      default: mode_nr = 4'd14;
    endcase
  endfunction

  function automatic logic mode_legal(input logic [1:0] m);
    mode_legal = (m != 2'd3) && (32 * int'(mode_nk(m)) <= MAX_KEY_WIDTH);
  endfunction

  state_e         state_q, state_d;
  logic [1:0]     mode_q, mode_d;
  logic [255:0]   key_q, key_d, key_ext;
  logic [IW-1:0]  idx_q, idx_d;
  logic [2:0]     pos_q, pos_d;
  logic [7:0]     rcon_q, rcon_d;
  logic           key_rdy_q, key_rdy_d;
  logic           key_err_q, key_err_d;
  logic [127:0]   rk_q, rk_d;
  logic [31:0]    w_q [WORD_DEPTH];

  logic [3:0]     nk, nr, eff_sel;
  logic [IW-1:0]  nk_w, last_w, base;
  logic [31:0]    prev_w, back_w, sub_in, sub_w, temp_w, new_w;
  logic           sel_ok;
  logic [127:0]   rk_word;

  always_comb begin
    key_ext = '0;
    key_ext[255 -: MAX_KEY_WIDTH] = bus.cipher_key;
  end

  // Expansion datapath: pos_q tracks i mod Nk so no divider is needed.
  always_comb begin
    nk     = mode_nk(mode_q);
    nr     = mode_nr(mode_q);
    nk_w   = IW'(nk);
    last_w = IW'({nr, 2'b11});
    prev_w = w_q[idx_q - IW'(1)];
    back_w = w_q[idx_q - nk_w];
    sub_in = (pos_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    sub_w  = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
    if (pos_q == 3'd0) begin
      temp_w = sub_w ^ {rcon_q, 24'h0};
    end else if (nk == 4'd8 && pos_q == 3'd4) begin
      temp_w = sub_w;
    end else begin
      temp_w = prev_w;
    end
    new_w = back_w ^ temp_w;
  end

  // Range check uses the raw key_sel; reverse indexing only remaps a legal index.
  always_comb begin
    sel_ok = (bus.key_sel <= nr);
`ifdef AES_KEY_INV_SEL_EN
    eff_sel = bus.key_dir ? (nr - bus.key_sel) : bus.key_sel;
`else
    eff_sel = bus.key_sel;
`endif
    base    = sel_ok ? IW'({eff_sel, 2'b00}) : '0;
    rk_word = {w_q[base], w_q[base + IW'(1)], w_q[base + IW'(2)], w_q[base + IW'(3)]};
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    key_d     = key_q;
    idx_d     = idx_q;
    pos_d     = pos_q;
    rcon_d    = rcon_q;
    key_rdy_d = key_rdy_q;
    key_err_d = 1'b0;
    rk_d      = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.encrypt_en) begin
          if (mode_legal(bus.key_mode)) begin
            state_d   = S_LOAD;
            mode_d    = bus.key_mode;
            key_d     = key_ext;
            key_rdy_d = 1'b0;
          end else begin
            key_err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        idx_d   = nk_w;
        pos_d   = 3'd0;
        rcon_d  = 8'h01;
        state_d = S_EXPAND;
      end
      S_EXPAND: begin
        idx_d = idx_q + IW'(1);
        pos_d = (pos_q == 3'(nk - 4'd1)) ? 3'd0 : pos_q + 3'd1;
        if (pos_q == 3'd0) begin
          rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        end
        if (idx_q == last_w) begin
          state_d   = S_DONE;
          key_rdy_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q == S_DONE && state_d == S_DONE) begin
      if (sel_ok) begin
        rk_d = rk_word;
      end else begin
        key_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      key_q     <= '0;
      idx_q     <= '0;
      pos_q     <= '0;
      rcon_q    <= 8'h01;
      key_rdy_q <= 1'b0;
      key_err_q <= 1'b0;
      rk_q      <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      key_q     <= key_d;
      idx_q     <= idx_d;
      pos_q     <= pos_d;
      rcon_q    <= rcon_d;
      key_rdy_q <= key_rdy_d;
      key_err_q <= key_err_d;
      rk_q      <= rk_d;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && state_q == S_LOAD) begin
      for (int k = 0; k < 8; k++) begin
        if (k < int'(nk)) w_q[k] <= key_q[255 - 32*k -: 32];
      end
    end else if (resetn && state_q == S_EXPAND) begin
      w_q[idx_q] <= new_w;
    end
  end

  assign bus.key_rdy   = key_rdy_q;
  assign bus.key_err   = key_err_q;
  assign bus.round_key = rk_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_aes_key_schedule_multi.sv
// Bench for aes_key_schedule_multi: FIPS-197 vectors for all three key sizes, latency,
// range/mode errors, ignored re-start, and reset during expansion.
`timescale 1ns/1ps
module tb_aes_key_schedule_multi;
  logic       clk;
  logic       resetn;
  logic [1:0] dbg_state;

  aes_key_schedule_multi_if #(.MAX_KEY_WIDTH(256)) bus ();

  aes_key_schedule_multi #(.MAX_KEY_WIDTH(256), .WORD_DEPTH(60)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  localparam logic [1:0] ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_EXPAND = 2'd2, ST_DONE = 2'd3;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  localparam logic [127:0] R128_0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R192_0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
  localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R256_0  = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [127:0] R256_1  = 128'h1f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  int n_vec;
  int n_err;
  logic [128:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [128:0] got, input logic [128:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Latency counts edges including the one that samples encrypt_en.
  task automatic start_key(input string tag, input logic [1:0] mode, input logic [255:0] key,
                           input int exp_lat, input int repulse_at);
    int edges;
    edges = 0;
    @(negedge clk);
    bus.key_mode   = mode;
    bus.cipher_key = key;
    bus.encrypt_en = 1'b1;
    while (edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) begin
        bus.encrypt_en = 1'b0;
        check({tag, "_load_state"}, 129'(dbg_state), 129'(ST_LOAD));
        check({tag, "_busy_rdy"}, 129'(bus.key_rdy), 129'(0));
        check({tag, "_busy_rk"}, 129'(bus.round_key), 129'(0));
      end
      if (repulse_at > 0 && edges == repulse_at) bus.encrypt_en = 1'b1;
      if (repulse_at > 0 && edges == repulse_at + 1) bus.encrypt_en = 1'b0;
      if (bus.key_rdy) break;
    end
    check({tag, "_latency"}, 129'(edges), 129'(exp_lat));
    check({tag, "_done_state"}, 129'(dbg_state), 129'(ST_DONE));
  endtask

  task automatic read_key(input string tag, input logic [3:0] sel, input logic [127:0] exp_key,
                          input logic exp_err);
    logic [128:0] e;
    @(negedge clk);
    bus.key_sel = sel;
    exp_q.push_back({exp_err, exp_key});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, "_rk"}, 129'(bus.round_key), 129'(e[127:0]));
    check({tag, "_err"}, 129'(bus.key_err), 129'(e[128]));
  endtask

  initial begin
    int edges;
    n_vec = 0;
    n_err = 0;
    resetn         = 1'b0;
    bus.cipher_key = '0;
    bus.key_mode   = 2'd0;
    bus.encrypt_en = 1'b0;
    bus.key_sel    = 4'd0;
`ifdef AES_KEY_INV_SEL_EN
    bus.key_dir    = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 129'(dbg_state), 129'(ST_IDLE));
    check("rst_rdy", 129'(bus.key_rdy), 129'(0));
    check("rst_err", 129'(bus.key_err), 129'(0));
    check("rst_rk", 129'(bus.round_key), 129'(0));
    @(negedge clk);
    resetn = 1'b1;

    // Illegal mode: one-cycle error, FSM holds IDLE.
    @(negedge clk);
    bus.key_mode   = 2'd3;
    bus.encrypt_en = 1'b1;
    @(posedge clk);
    #1;
    bus.encrypt_en = 1'b0;
    check("bad_mode_err", 129'(bus.key_err), 129'(1));
    check("bad_mode_state", 129'(dbg_state), 129'(ST_IDLE));
    @(posedge clk);
    #1;
    check("bad_mode_err_clr", 129'(bus.key_err), 129'(0));

    start_key("aes128", 2'd0, K128, 42, 0);
    read_key("a128_r0", 4'd0, R128_0, 1'b0);
    read_key("a128_r1", 4'd1, R128_1, 1'b0);
    read_key("a128_r10", 4'd10, R128_10, 1'b0);
    read_key("a128_r11", 4'd11, 128'h0, 1'b1);
    read_key("a128_rnd_oor", 4'($urandom_range(11, 15)), 128'h0, 1'b1);
    read_key("a128_r10b", 4'd10, R128_10, 1'b0);
    repeat ($urandom_range(1, 4)) @(negedge clk);

    // Restart from DONE with a re-pulse mid-EXPAND that must be ignored.
    start_key("aes128_rep", 2'd0, K128, 42, 10);
    read_key("a128rep_r10", 4'd10, R128_10, 1'b0);

    start_key("aes192", 2'd1, K192, 48, 0);
    read_key("a192_r0", 4'd0, R192_0, 1'b0);
    read_key("a192_r12", 4'd12, R192_12, 1'b0);
    read_key("a192_r13", 4'd13, 128'h0, 1'b1);
    repeat ($urandom_range(1, 4)) @(negedge clk);

    start_key("aes256", 2'd2, K256, 54, 0);
    read_key("a256_r0", 4'd0, R256_0, 1'b0);
    read_key("a256_r1", 4'd1, R256_1, 1'b0);
    read_key("a256_r14", 4'd14, R256_14, 1'b0);
    read_key("a256_r15", 4'd15, 128'h0, 1'b1);

    // Reset at the edge that would write word 20 of an AES-128 expansion.
    @(negedge clk);
    bus.key_mode   = 2'd0;
    bus.cipher_key = K128;
    bus.encrypt_en = 1'b1;
    edges = 0;
    while (edges < 18) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) bus.encrypt_en = 1'b0;
    end
    check("midrst_pre_state", 129'(dbg_state), 129'(ST_EXPAND));
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_state", 129'(dbg_state), 129'(ST_IDLE));
    check("midrst_rdy", 129'(bus.key_rdy), 129'(0));
    check("midrst_rk", 129'(bus.round_key), 129'(0));
    resetn = 1'b1;
    start_key("aes128_post", 2'd0, K128, 42, 0);
    read_key("post_r10", 4'd10, R128_10, 1'b0);

`ifdef AES_KEY_INV_SEL_EN
    @(negedge clk);
    bus.key_dir = 1'b1;
    read_key("inv_r0", 4'd0, R128_10, 1'b0);
    read_key("inv_r10", 4'd10, R128_0, 1'b0);
    read_key("inv_r11", 4'd11, 128'h0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
